// File: rtl/kbd_matrix.sv
`default_nettype none
// ============================================================================
// Module      : kbd_matrix
// Description : Host-written keyboard matrix that intercepts CPU column reads.
//               Optional press stretching enabled by macro KBD_MATRIX_HOLD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module kbd_matrix #(
    parameter int          ROWS       = 10,
    parameter int          COLS       = 8,
    parameter logic [16:0] PI_BASE    = 17'hE800,
    parameter logic [16:0] SEL_ADDR   = 17'hE810,
    parameter logic [16:0] COL_ADDR   = 17'hE812,
    parameter int          HOLD_SCANS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [16:0] addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    input  logic        cpu_read_strobe,
    input  logic        cpu_write_strobe,
    input  logic        pi_write_strobe,
    output logic        oe
);

    localparam logic [16:0]     c_ROWS_A = 17'(ROWS);
    localparam logic [4:0]      c_ROWS_S = 5'(ROWS);
    localparam logic [COLS-1:0] c_ONES   = '1;

    logic                r_cpu_rd_q, r_cpu_wr_q, r_pi_wr_q;
    logic [3:0]          r_sel;
    logic [COLS-1:0]     r_matrix [ROWS];

    logic                w_cpu_rd_ev, w_cpu_wr_ev, w_pi_wr_ev;
    logic [16:0]         w_pi_off;
    logic [3:0]          w_pi_row;
    logic                w_pi_hit;
    logic                w_sel_wr;
    logic                w_sel_valid;
    logic                w_col_rd;
    logic [COLS-1:0]     w_eff_row;

    // Each strobe acts on its rising edge only, however long it stays high.
    assign w_cpu_rd_ev = cpu_read_strobe  & ~r_cpu_rd_q;
    assign w_cpu_wr_ev = cpu_write_strobe & ~r_cpu_wr_q;
    assign w_pi_wr_ev  = pi_write_strobe  & ~r_pi_wr_q;

    assign w_pi_off    = addr - PI_BASE;
    assign w_pi_row    = w_pi_off[3:0];
    assign w_pi_hit    = w_pi_wr_ev && (addr >= PI_BASE) && (w_pi_off < c_ROWS_A);
    assign w_sel_wr    = w_cpu_wr_ev && (addr == SEL_ADDR);
    assign w_sel_valid = ({1'b0, r_sel} < c_ROWS_S);
    assign w_col_rd    = w_cpu_rd_ev && (addr == COL_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cpu_rd_q <= 1'b0;
            r_cpu_wr_q <= 1'b0;
            r_pi_wr_q  <= 1'b0;
            r_sel      <= 4'd0;
            for (int r = 0; r < ROWS; r++) begin
                r_matrix[r] <= c_ONES;
            end
        end else begin
            r_cpu_rd_q <= cpu_read_strobe;
            r_cpu_wr_q <= cpu_write_strobe;
            r_pi_wr_q  <= pi_write_strobe;
            if (w_sel_wr) begin
                r_sel <= data_in[3:0];
            end
            if (w_pi_hit) begin
                r_matrix[w_pi_row] <= data_in[COLS-1:0];
            end
        end
    end

`ifdef KBD_MATRIX_HOLD_EN
    localparam logic [3:0] c_HOLD = 4'(HOLD_SCANS);

    logic [COLS-1:0] r_held [ROWS];
    logic [3:0]      r_cnt  [ROWS];
    logic [ROWS-1:0] w_new_clr;
    logic [ROWS-1:0] w_expire;
    logic [ROWS-1:0] w_cnt_rd;

    always_comb begin
        w_new_clr = '0;
        w_expire  = '0;
        w_cnt_rd  = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_new_clr[r] = w_pi_hit && (w_pi_row == 4'(r)) &&
                           (|(r_held[r] & ~data_in[COLS-1:0]));
            w_expire[r]  = (r_cnt[r] == c_HOLD);
            w_cnt_rd[r]  = w_col_rd && w_sel_valid && (r_sel == 4'(r)) &&
                           (r_held[r] != c_ONES);
        end
    end

    // A fresh press restarts the stretch and outranks expiry or a counted scan.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++) begin
                r_held[r] <= c_ONES;
                r_cnt[r]  <= 4'd0;
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                if (w_new_clr[r]) begin
                    r_held[r] <= r_held[r] & data_in[COLS-1:0];
                    r_cnt[r]  <= 4'd0;
                end else if (w_expire[r]) begin
                    r_held[r] <= c_ONES;
                    r_cnt[r]  <= 4'd0;
                end else if (w_cnt_rd[r]) begin
                    r_cnt[r]  <= r_cnt[r] + 4'd1;
                end
            end
        end
    end
`endif

    always_comb begin
        w_eff_row = c_ONES;
        if (w_sel_valid) begin
`ifdef KBD_MATRIX_HOLD_EN
            w_eff_row = r_matrix[r_sel] & r_held[r_sel];
`else
            w_eff_row = r_matrix[r_sel];
`endif
        end
        data_out              = 8'hFF;
        data_out[COLS-1:0]    = w_eff_row;
    end

    assign oe = ~(cpu_read_strobe && (addr == COL_ADDR) && (data_out != 8'hFF));

endmodule
`default_nettype wire

// File: tb/tb_kbd_matrix.sv
`default_nettype none
// ============================================================================
// Module      : tb_kbd_matrix
// Description : Directed self-checking bench for kbd_matrix (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kbd_matrix;

    logic        clk = 1'b0;
    logic        reset;
    logic [16:0] addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        cpu_read_strobe;
    logic        cpu_write_strobe;
    logic        pi_write_strobe;
    logic        oe;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] rd_d;
    logic       rd_oe;

    kbd_matrix dut (
        .clk              (clk),
        .reset            (reset),
        .addr             (addr),
        .data_in          (data_in),
        .data_out         (data_out),
        .cpu_read_strobe  (cpu_read_strobe),
        .cpu_write_strobe (cpu_write_strobe),
        .pi_write_strobe  (pi_write_strobe),
        .oe               (oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic pi_write(input logic [16:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        addr = a; data_in = d; pi_write_strobe = 1'b1;
        @(posedge clk); #1;
        pi_write_strobe = 1'b0;
    endtask

    task automatic cpu_write(input logic [16:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        addr = a; data_in = d; cpu_write_strobe = 1'b1;
        @(posedge clk); #1;
        cpu_write_strobe = 1'b0;
    endtask

    task automatic cpu_read(input logic [16:0] a, output logic [7:0] d, output logic o);
        @(posedge clk); #1;
        addr = a; cpu_read_strobe = 1'b1;
        #1;
        d = data_out;
        o = oe;
        @(posedge clk); #1;
        cpu_read_strobe = 1'b0;
    endtask

    initial begin
        reset = 1'b1; addr = '0; data_in = '0;
        cpu_read_strobe = 1'b0; cpu_write_strobe = 1'b0; pi_write_strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout", data_out, 8'hFF);
        check("reset_oe", {7'd0, oe}, 8'h01);
        reset = 1'b0;

        cpu_read(17'hE812, rd_d, rd_oe);
        check("rst_read_dout", rd_d, 8'hFF);
        check("rst_read_oe", {7'd0, rd_oe}, 8'h01);

        // Basic intercept.
        pi_write(17'hE803, 8'hFE);
        cpu_write(17'hE810, 8'h03);
        check("sel3_visible", data_out, 8'hFE);
        addr = 17'hE812;
        #1;
        check("oe_no_strobe", {7'd0, oe}, 8'h01);
        cpu_read(17'hE812, rd_d, rd_oe);
        check("row3_dout", rd_d, 8'hFE);
        check("row3_oe", {7'd0, rd_oe}, 8'h00);
        #1;
        check("oe_after_read", {7'd0, oe}, 8'h01);

        // Wrong read address never intercepts.
        cpu_read(17'hE811, rd_d, rd_oe);
        check("wrong_addr_oe", {7'd0, rd_oe}, 8'h01);

        pi_write(17'hE800, 8'h5A);
        cpu_write(17'hE810, 8'h00);
        cpu_read(17'hE812, rd_d, rd_oe);
        check("row0_dout", rd_d, 8'h5A);
        check("row0_oe", {7'd0, rd_oe}, 8'h00);

        // Row range boundaries.
        pi_write(17'hE80A, 8'h00);
        pi_write(17'hE7FF, 8'h00);
        cpu_write(17'hE810, 8'h09);
        cpu_read(17'hE812, rd_d, rd_oe);
        check("row9_untouched", rd_d, 8'hFF);
        pi_write(17'hE809, 8'h7F);
        cpu_read(17'hE812, rd_d, rd_oe);
        check("row9_last", rd_d, 8'h7F);
        cpu_write(17'hE810, 8'h00);
        cpu_read(17'hE812, rd_d, rd_oe);
        check("row0_after_oob", rd_d, 8'h5A);

        // Out-of-range select.
        cpu_write(17'hE810, 8'h0C);
        cpu_read(17'hE812, rd_d, rd_oe);
        check("sel_oob_dout", rd_d, 8'hFF);
        check("sel_oob_oe", {7'd0, rd_oe}, 8'h01);

        // Long pi strobe is a single event; later data must not land.
        @(posedge clk); #1;
        addr = 17'hE806; data_in = 8'h00; pi_write_strobe = 1'b1;
        @(posedge clk); #1;
        data_in = 8'hFF;
        repeat (9) @(posedge clk);
        #1;
        pi_write_strobe = 1'b0;
        cpu_write(17'hE810, 8'h06);
        cpu_read(17'hE812, rd_d, rd_oe);
        check("long_strobe_row6", rd_d, 8'h00);

        // Press stretching.
        pi_write(17'hE805, 8'hF7);
        pi_write(17'hE805, 8'hFF);
        cpu_write(17'hE810, 8'h05);
`ifdef KBD_MATRIX_HOLD_EN
        cpu_read(17'hE812, rd_d, rd_oe);
        check("hold_read1", rd_d, 8'hF7);
        cpu_read(17'hE812, rd_d, rd_oe);
        check("hold_read2", rd_d, 8'hF7);
        cpu_read(17'hE812, rd_d, rd_oe);
        check("hold_read3", rd_d, 8'hFF);
`else
        cpu_read(17'hE812, rd_d, rd_oe);
        check("nohold_read1", rd_d, 8'hFF);
        check("nohold_oe", {7'd0, rd_oe}, 8'h01);
`endif

        // Reset mid-hold, asserted between clock edges.
        pi_write(17'hE802, 8'hFB);
        pi_write(17'hE802, 8'hFF);
        cpu_write(17'hE810, 8'h03);
        check("pre_reset_row3", data_out, 8'hFE);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_dout", data_out, 8'hFF);
        @(posedge clk); #1;
        reset = 1'b0;
        cpu_write(17'hE810, 8'h02);
        cpu_read(17'hE812, rd_d, rd_oe);
        check("reset_mid_hold", rd_d, 8'hFF);
        check("reset_mid_hold_oe", {7'd0, rd_oe}, 8'h01);
        cpu_write(17'hE810, 8'h03);
        check("row3_cleared", data_out, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kbd_matrix.md
KBD_MATRIX -- requirements
Module: kbd_matrix

Interface
- REQ-001 The module SHALL have parameter ROWS, default 10, giving the number of keyboard matrix rows (2..16).
- REQ-002 The module SHALL have parameter COLS, default 8, giving the number of columns per row (1..8).
- REQ-003 The module SHALL have parameter PI_BASE, default 17'hE800, giving the address of row 0 for host writes.
- REQ-004 The module SHALL have parameter SEL_ADDR, default 17'hE810, giving the row-select port address.
- REQ-005 The module SHALL have parameter COL_ADDR, default 17'hE812, giving the column-read port address.
- REQ-006 The module SHALL have parameter HOLD_SCANS, default 2, giving the minimum CPU scans per press (1..15).
- REQ-007 The module SHALL have ports: clk input 1, the single system clock; reset input 1, asynchronous active-high reset; addr input 17, bus address; data_in input 8, bus write data; data_out output 8, matrix column data, active-low keys; cpu_read_strobe input 1, CPU read cycle; cpu_write_strobe input 1, CPU write cycle; pi_write_strobe input 1, host write cycle; oe output 1, active-low intercept, 0 means data_out drives the bus in place of the PIA.

Function
- REQ-008 All three strobes SHALL be registered once; an event SHALL occur in the first clk cycle in which the strobe is high and its registered copy is low. Each event SHALL act exactly once per strobe assertion.
- REQ-009 On a cpu_write_strobe event with addr == SEL_ADDR, sel SHALL load data_in[3:0] on the next clk edge.
- REQ-010 On a pi_write_strobe event with PI_BASE <= addr <= PI_BASE+ROWS-1, matrix[addr-PI_BASE] SHALL load data_in[COLS-1:0] on the next clk edge. Other addresses SHALL be ignored.
- REQ-011 The effective row SHALL be matrix[sel] AND held[sel] when HOLD is compiled in, and matrix[sel] otherwise.
- REQ-012 data_out SHALL be combinational: the effective row in bits [COLS-1:0], with all unused high bits at 1.
- REQ-013 When sel >= ROWS, data_out SHALL be 8'hFF.
- REQ-014 oe SHALL be combinational, 0 iff cpu_read_strobe == 1, addr == COL_ADDR, and data_out != 8'hFF; otherwise oe SHALL be 1.
- REQ-015 A pi write and a CPU select write in the same cycle SHALL both take effect. The new sel SHALL be visible on data_out one cycle after the edge.

Reset
- REQ-016 While reset is high, the module SHALL hold: every matrix row all-ones; every held row all-ones; every hold counter 0; sel = 0; all strobe registers 0.
- REQ-017 Out of reset, data_out SHALL be 8'hFF and oe SHALL be 1.
- REQ-018 Asserting reset mid-press SHALL discard all pending holds immediately.

Configuration
- REQ-019 Macro KBD_MATRIX_HOLD_EN SHALL enable press stretching. When it is undefined, the held registers and counters SHALL NOT exist and the effective row SHALL equal matrix[sel].
- REQ-020 With KBD_MATRIX_HOLD_EN, a pi write to row r SHALL clear held[r] bits wherever new data has 0 and held[r] has 1, and SHALL reset cnt[r] to 0 if any bit was newly cleared.
- REQ-021 With KBD_MATRIX_HOLD_EN, a cpu_read_strobe event with addr == COL_ADDR, sel == r < ROWS, and held[r] != all-ones SHALL increment cnt[r], saturating at HOLD_SCANS.
- REQ-022 When cnt[r] reaches HOLD_SCANS, held[r] SHALL return to all-ones and cnt[r] to 0 on the following clk edge. A key still low in matrix[r] SHALL remain pressed.
- REQ-023 If a pi write newly clearing bits in row r and a counted read of row r occur in the same cycle, the write SHALL win: cnt[r] = 0 and the read SHALL NOT be counted.

Verification
- REQ-024 Reset check: assert reset, then read $E812 with sel = 0 -> data_out = FF, oe = 1.
- REQ-025 Basic intercept: pi writes $E803 = FE, CPU writes $E810 = 03, CPU reads $E812 -> data_out = FE, oe = 0 during the read strobe only.
- REQ-026 Out-of-range select: CPU writes $E810 = 0C with ROWS = 10 -> data_out = FF, oe = 1.
- REQ-027 Hold (macro on, HOLD_SCANS = 2): pi writes $E805 = F7 then $E805 = FF before any scan. With sel = 5, the 1st and 2nd reads both return F7; the 3rd read returns FF. With the macro off, the 1st read returns FF.
- REQ-028 Strobe held high for 10 cycles on a pi write SHALL count as one event, and cnt SHALL be unchanged by that write.
- REQ-029 Reset mid-hold: a pending hold on row 2 followed by a reset pulse, then sel = 2 and a read -> data_out = FF.
